bram_responder: RTL
===================

// Module: bram_responder
// PURPOSE
//   Behavioural/synthesizable responder for one fabric BRAM port group
//   (rd_addr, wr_addr, wr_data, config -> rd_data). It answers a user design
//   that drives the port group, so user designs run in simulation and on the
//   bring-up board without the hard BRAM macro.
//   It is a 2^ADDR_WIDTH x 32 memory with config-selected port widths, a
//   write enable and an optional output register. It clears its contents
//   after reset.
// PARAMETERS
//   ADDR_WIDTH      8   address bits; depth = 2**ADDR_WIDTH words of 32 bits
//   DATA_WIDTH      32  port data width; only 32 is supported (elaboration error otherwise)
//   CLEAR_ON_RESET  1   1: zero-fill sweep after reset; 0: contents kept, init_busy never set
// PORTS
//   clk        in   1           single clock, all logic on posedge
//   rst        in   1           synchronous, active-high reset
//   rd_addr    in   ADDR_WIDTH  read address
//   wr_addr    in   ADDR_WIDTH  write address
//   wr_data    in   32          write data; narrow modes use the low bits only
//   config     in   8           [1:0] wr width, [3:2] rd width (00=32,01=16,10=8,11=4 bit);
//                               [4] always-write; [5] write strobe (used when [4]=0);
//                               [6] extra output register; [7] reserved, ignored
//   rd_data    out  32          read data, zero-extended in narrow modes
//   init_busy  out  1           high while the clear sweep runs
// BEHAVIOUR
//   - Reset values: rd_data=0, init_busy=CLEAR_ON_RESET, sweep pointer=0, output pipe regs=0.
//   - FSM states: INIT and RUN.
//     - rst forces INIT (CLEAR_ON_RESET=1) or RUN (=0).
//     - In INIT, one word at the pointer is written to 0 per cycle.
//     - The pointer wraps from 2**ADDR_WIDTH-1, then the FSM goes to RUN and init_busy drops.
//     - The sweep takes exactly 2**ADDR_WIDTH cycles after rst deasserts.
//     - rst during INIT restarts the sweep at 0.
//     - In INIT, user writes are ignored and rd_data is held at 0.
//   - Lane addressing for width W:
//     - lanes per word = 32/W.
//     - word index = addr >> log2(32/W).
//     - lane index = addr low log2(32/W) bits; lane 0 = bits [W-1:0].
//     - Narrow modes therefore reach only 2**ADDR_WIDTH*W/32 words.
//   - Write: occurs on posedge when in RUN and (config[4] | config[5]).
//     - Only the selected lane's W bits change, taken from wr_data[W-1:0].
//     - The other bits of the word are preserved.
//   - Read: synchronous.
//     - The word is sampled on the posedge and the selected lane is zero-extended.
//     - Latency is 1 cycle when config[6]=0 and 2 cycles when config[6]=1.
//     - Changing config[6] takes effect on the next cycle; one stale or duplicate value is allowed.
//   - Read-during-write to the same word is read-first: rd_data shows the old word, and the new
//     value is visible on the next read.
//   - config is sampled every cycle, with no registered mode state.
//   - Read and write widths are independent, e.g. write 8-bit and read 32-bit.
//   - Addresses use natural wrap in ADDR_WIDTH bits; no out-of-range case exists.
// TESTING
//   1. Reset then idle.
//      -> init_busy high for 256 cycles, then low.
//      -> Reading any address returns 32'h0.
//   2. 32-bit mode, config=8'h10, write A at addr n each cycle while reading n-1.
//      -> rd_data equals the value written to n-1, one cycle late.
//      -> Check the wrap from 255 to 0.
//   3. Same-cycle read/write of addr 5: old=32'h11111111, new=32'hDEADBEEF.
//      -> rd_data=32'h11111111 next cycle, then 32'hDEADBEEF on the following read.
//   4. Write 8-bit (config[1:0]=10) 8'hAB to addr 6, then read 32-bit at word 1.
//      -> Result 32'h00AB0000, other lanes unchanged.
//   5. config=8'h00, no strobe, drive writes.
//      -> Memory unchanged.
//      -> With config=8'h20 the writes land.
//   6. Assert rst mid-sweep at pointer 100, and set config[6]=1.
//      -> Sweep restarts at 0 and takes 256 cycles.
//      -> With config[6]=1, read latency is 2 cycles.

Source files
------------

// File: rtl/bram_responder.sv
// 2**ADDR_WIDTH x 32 BRAM stand-in with config-selected lane widths and zero-fill after reset.
// Read latency 1 cycle, or 2 with config[6]; no backpressure, and the port is accepted every cycle.
module bram_responder #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [31:0]           i_wr_data,
  input  logic [7:0]            i_config,
  output logic [31:0]           o_rd_data,
  output logic                  o_init_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  generate
    if (DATA_WIDTH != 32) begin : g_bad_width
      $error("bram_responder supports only DATA_WIDTH = 32");
    end
    if (ADDR_WIDTH < 3) begin : g_bad_addr
      $error("bram_responder needs ADDR_WIDTH >= 3 for 4-bit lanes");
    end
  endgenerate

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] w_ptr_nxt;
  logic                  w_sweep_we;
  logic                  w_user_en;
  logic [31:0]           r_mem [DEPTH];
  logic [31:0]           r_rd1;
  logic [31:0]           r_rd2;

  // Width code c selects a 32>>c bit lane; all lanes of one word share addr >> c.
  function automatic logic [31:0] lane_mask(input logic [1:0] c);
    case (c)
      2'd0:    lane_mask = 32'hFFFF_FFFF;
      2'd1:    lane_mask = 32'h0000_FFFF;
      2'd2:    lane_mask = 32'h0000_00FF;
      default: lane_mask = 32'h0000_000F;
    endcase
  endfunction

  function automatic logic [4:0] lane_off(input logic [2:0] a, input logic [1:0] c);
    logic [4:0] lane;
    lane     = {2'b00, a} & ((5'd1 << c) - 5'd1);
    lane_off = lane << (3'd5 - {1'b0, c});
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sweep_we  = 1'b0;
    w_user_en   = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_sweep_we = 1'b1;
        w_ptr_nxt  = r_ptr + ADDR_WIDTH'(1);
        if (r_ptr == '1) w_state_nxt = ST_RUN;
      end
      ST_RUN: w_user_en = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  logic [ADDR_WIDTH-1:0] w_wr_idx;
  logic [ADDR_WIDTH-1:0] w_rd_idx;
  logic [4:0]            w_wr_off;
  logic [4:0]            w_rd_off;
  logic [31:0]           w_wr_mask;
  logic [31:0]           w_wr_word;
  logic [31:0]           w_rd_lane;
  logic                  w_wr_en;
  logic                  w_unused;

  assign w_wr_idx  = i_wr_addr >> i_config[1:0];
  assign w_rd_idx  = i_rd_addr >> i_config[3:2];
  assign w_wr_off  = lane_off(i_wr_addr[2:0], i_config[1:0]);
  assign w_rd_off  = lane_off(i_rd_addr[2:0], i_config[3:2]);
  assign w_wr_mask = lane_mask(i_config[1:0]) << w_wr_off;
  assign w_wr_word = (r_mem[w_wr_idx] & ~w_wr_mask)
                   | ((i_wr_data & lane_mask(i_config[1:0])) << w_wr_off);
  assign w_rd_lane = (r_mem[w_rd_idx] >> w_rd_off) & lane_mask(i_config[3:2]);
  assign w_wr_en   = i_config[4] | i_config[5];
  assign w_unused  = i_config[7];

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (w_sweep_we) r_mem[r_ptr] <= '0;
      else if (w_user_en && w_wr_en) r_mem[w_wr_idx] <= w_wr_word;
    end
  end

  // Nonblocking read of the old word gives read-first behaviour on same-word collisions.
  always_ff @(posedge i_clk) begin
    if (i_rst || !w_user_en) begin
      r_rd1 <= '0;
      r_rd2 <= '0;
    end else begin
      r_rd1 <= w_rd_lane;
      r_rd2 <= r_rd1;
    end
  end

  assign o_rd_data   = i_config[6] ? r_rd2 : r_rd1;
  assign o_init_busy = (r_state == ST_INIT);

endmodule
